ifft_r4_butterfly_pipe: RTL and testbench

- Pipelined inverse radix-4 butterfly for the 16-point IFFT path. It is the inverse-direction counterpart of the forward radix-4 butterfly.
- Per transaction: takes four complex samples A..D and applies the conjugate twiddles to B, C and D. It then computes the inverse 4-point DFT and scales the result by 1/4.
- Two passes through the block give the full 1/16 IFFT normalisation.
- Valid/ready on both sides, 3-cycle latency, sticky saturation flag.

---
 rtl/ifft_r4_butterfly_pipe.sv | 228 ++++++++++++++++++++++
 tb/tb_ifft_r4_butterfly_pipe.sv | 295 +++++++++++++++++++++++++++++
 2 files changed

// File: rtl/ifft_r4_butterfly_pipe.sv
// Inverse radix-4 butterfly for the 16-point IFFT path.
// Three pipeline stages:
//   1. capture A and form the twiddle partial products,
//   2. finish the complex multiplies with rounding and saturation,
//   3. run the inverse 4-point DFT with a 1/4 scale.
// A single global enable advances every stage together, so backpressure
// freezes the whole pipe, bubbles included.
module ifft_r4_butterfly_pipe #(
  parameter int DW    = 16,
  parameter int TW    = 16,
  parameter int TFRAC = 14
) (
  input  logic                 clk,
  input  logic                 rst_n,
  input  logic                 in_valid,
  output logic                 in_ready,
  input  logic signed [DW-1:0] ar,
  input  logic signed [DW-1:0] ai,
  input  logic signed [DW-1:0] br,
  input  logic signed [DW-1:0] bi,
  input  logic signed [DW-1:0] cr,
  input  logic signed [DW-1:0] ci,
  input  logic signed [DW-1:0] dr,
  input  logic signed [DW-1:0] di,
  input  logic signed [TW-1:0] w1r,
  input  logic signed [TW-1:0] w1i,
  input  logic signed [TW-1:0] w2r,
  input  logic signed [TW-1:0] w2i,
  input  logic signed [TW-1:0] w3r,
  input  logic signed [TW-1:0] w3i,
  output logic                 out_valid,
  input  logic                 out_ready,
  output logic signed [DW-1:0] y0r,
  output logic signed [DW-1:0] y0i,
  output logic signed [DW-1:0] y1r,
  output logic signed [DW-1:0] y1i,
  output logic signed [DW-1:0] y2r,
  output logic signed [DW-1:0] y2i,
  output logic signed [DW-1:0] y3r,
  output logic signed [DW-1:0] y3i,
  output logic                 sat_sticky,
  input  logic                 sat_clr
);

  // Product width, complex-sum width (one guard bit), DFT width.
  localparam int PW = DW + TW;
  localparam int SW = PW + 1;
  localparam int XW = DW + 2;

  localparam logic signed [SW-1:0] RND  = {{(SW-TFRAC){1'b0}}, 1'b1, {(TFRAC-1){1'b0}}};
  localparam logic signed [SW-1:0] SMAX = {{(SW-DW+1){1'b0}}, {(DW-1){1'b1}}};
  localparam logic signed [SW-1:0] SMIN = {{(SW-DW+1){1'b1}}, {(DW-1){1'b0}}};
  localparam logic signed [XW-1:0] RND2 = {{(XW-2){1'b0}}, 2'b10};

  // Full-width signed product of a sample component and a twiddle component.
  function automatic logic signed [PW-1:0] smul(input logic signed [DW-1:0] x,
                                                input logic signed [TW-1:0] w);
    return PW'(x) * PW'(w);
  endfunction

  function automatic logic is_ovf(input logic signed [SW-1:0] v);
    return (v > SMAX) || (v < SMIN);
  endfunction

  function automatic logic signed [DW-1:0] sat_dw(input logic signed [SW-1:0] v);
    logic signed [DW-1:0] r;
    if (v > SMAX)      r = SMAX[DW-1:0];
    else if (v < SMIN) r = SMIN[DW-1:0];
    else               r = v[DW-1:0];
    return r;
  endfunction

  function automatic logic signed [XW-1:0] ext(input logic signed [DW-1:0] x);
    return XW'(x);
  endfunction

  function automatic logic signed [DW-1:0] quarter(input logic signed [XW-1:0] v);
    logic signed [XW-1:0] t;
    t = (v + RND2) >>> 2;
    return t[DW-1:0];
  endfunction

  logic                 w_en;
  logic signed [DW-1:0] w_xr [3];
  logic signed [DW-1:0] w_xi [3];
  logic signed [TW-1:0] w_wr [3];
  logic signed [TW-1:0] w_wi [3];

  // Stage 1 registers: index 0..2 = B, C, D; products rr, ii, ri, ir.
  logic                 r1_valid;
  logic signed [DW-1:0] r1_ar;
  logic signed [DW-1:0] r1_ai;
  logic signed [PW-1:0] r1_p [3][4];

  // Stage 2 combinational results and registers.
  logic signed [SW-1:0] w_re_full [3];
  logic signed [SW-1:0] w_im_full [3];
  logic signed [DW-1:0] w_re [3];
  logic signed [DW-1:0] w_im [3];
  logic                 w_sat_any;
  logic                 w_sat_set;

  logic                 r2_valid;
  logic signed [DW-1:0] r2_ar;
  logic signed [DW-1:0] r2_ai;
  logic signed [DW-1:0] r2_xr [3];
  logic signed [DW-1:0] r2_xi [3];

  // Stage 3 combinational DFT sums and output registers.
  logic signed [XW-1:0] w_yr [4];
  logic signed [XW-1:0] w_yi [4];

  logic                 r_out_valid;
  logic signed [DW-1:0] r_yr [4];
  logic signed [DW-1:0] r_yi [4];
  logic                 r_sat;

  assign w_en     = !r_out_valid || out_ready;
  assign in_ready = w_en;

  assign w_xr[0] = br;  assign w_xi[0] = bi;  assign w_wr[0] = w1r;  assign w_wi[0] = w1i;
  assign w_xr[1] = cr;  assign w_xi[1] = ci;  assign w_wr[1] = w2r;  assign w_wi[1] = w2i;
  assign w_xr[2] = dr;  assign w_xi[2] = di;  assign w_wr[2] = w3r;  assign w_wi[2] = w3i;

  // Stage 1: capture A and the twelve partial products on acceptance.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r1_valid <= 1'b0;
      r1_ar    <= '0;
      r1_ai    <= '0;
      r1_p     <= '{default: '0};
    end else if (w_en) begin
      r1_valid <= in_valid;
      if (in_valid) begin
        r1_ar <= ar;
        r1_ai <= ai;
        for (int unsigned k = 0; k < 3; k++) begin
          r1_p[k][0] <= smul(w_xr[k], w_wr[k]);
          r1_p[k][1] <= smul(w_xi[k], w_wi[k]);
          r1_p[k][2] <= smul(w_xr[k], w_wi[k]);
          r1_p[k][3] <= smul(w_xi[k], w_wr[k]);
        end
      end
    end
  end

  // Stage 2 datapath: complex multiply finish, round half-up, saturate.
  always_comb begin
    w_re_full = '{default: '0};
    w_im_full = '{default: '0};
    w_re      = '{default: '0};
    w_im      = '{default: '0};
    w_sat_any = 1'b0;
    for (int unsigned k = 0; k < 3; k++) begin
      w_re_full[k] = (SW'(r1_p[k][0]) - SW'(r1_p[k][1]) + RND) >>> TFRAC;
      w_im_full[k] = (SW'(r1_p[k][2]) + SW'(r1_p[k][3]) + RND) >>> TFRAC;
      w_re[k]      = sat_dw(w_re_full[k]);
      w_im[k]      = sat_dw(w_im_full[k]);
      if (is_ovf(w_re_full[k]) || is_ovf(w_im_full[k])) w_sat_any = 1'b1;
    end
  end

  // Saturation only counts when a real vector moves through stage 2.
  assign w_sat_set = w_en && r1_valid && w_sat_any;

  // Stage 2 registers.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r2_valid <= 1'b0;
      r2_ar    <= '0;
      r2_ai    <= '0;
      r2_xr    <= '{default: '0};
      r2_xi    <= '{default: '0};
    end else if (w_en) begin
      r2_valid <= r1_valid;
      if (r1_valid) begin
        r2_ar <= r1_ar;
        r2_ai <= r1_ai;
        r2_xr <= w_re;
        r2_xi <= w_im;
      end
    end
  end

  // Stage 3 datapath: inverse 4-point DFT (twiddle +j for bin 1).
  always_comb begin
    w_yr[0] = ext(r2_ar) + ext(r2_xr[0]) + ext(r2_xr[1]) + ext(r2_xr[2]);
    w_yi[0] = ext(r2_ai) + ext(r2_xi[0]) + ext(r2_xi[1]) + ext(r2_xi[2]);
    w_yr[1] = ext(r2_ar) - ext(r2_xi[0]) - ext(r2_xr[1]) + ext(r2_xi[2]);
    w_yi[1] = ext(r2_ai) + ext(r2_xr[0]) - ext(r2_xi[1]) - ext(r2_xr[2]);
    w_yr[2] = ext(r2_ar) - ext(r2_xr[0]) + ext(r2_xr[1]) - ext(r2_xr[2]);
    w_yi[2] = ext(r2_ai) - ext(r2_xi[0]) + ext(r2_xi[1]) - ext(r2_xi[2]);
    w_yr[3] = ext(r2_ar) + ext(r2_xi[0]) - ext(r2_xr[1]) - ext(r2_xi[2]);
    w_yi[3] = ext(r2_ai) - ext(r2_xr[0]) - ext(r2_xi[1]) + ext(r2_xr[2]);
  end

  // Stage 3 registers: scaled outputs, held through stalls and bubbles.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_out_valid <= 1'b0;
      r_yr        <= '{default: '0};
      r_yi        <= '{default: '0};
    end else if (w_en) begin
      r_out_valid <= r2_valid;
      if (r2_valid) begin
        for (int unsigned k = 0; k < 4; k++) begin
          r_yr[k] <= quarter(w_yr[k]);
          r_yi[k] <= quarter(w_yi[k]);
        end
      end
    end
  end

  // Sticky saturation flag; a new saturation wins over a same-cycle clear.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n)         r_sat <= 1'b0;
    else if (w_sat_set) r_sat <= 1'b1;
    else if (sat_clr)   r_sat <= 1'b0;
  end

  assign out_valid  = r_out_valid;
  assign sat_sticky = r_sat;
  assign y0r = r_yr[0];  assign y0i = r_yi[0];
  assign y1r = r_yr[1];  assign y1i = r_yi[1];
  assign y2r = r_yr[2];  assign y2i = r_yi[2];
  assign y3r = r_yr[3];  assign y3i = r_yi[3];

endmodule

// File: tb/tb_ifft_r4_butterfly_pipe.sv
// Self-checking bench for ifft_r4_butterfly_pipe: directed vector table,
// random streams checked against an integer reference model, and
// hand-written sequences for stall, sticky flag and mid-stream reset.
module tb_ifft_r4_butterfly_pipe;
  localparam int DW = 16;
  localparam int TW = 16;

  // s: ar ai br bi cr ci dr di (index 7 = ar); w: w1r w1i w2r w2i w3r w3i;
  // y: y0r y0i y1r y1i y2r y2i y3r y3i.
  typedef struct packed {
    logic [7:0][DW-1:0] s;
    logic [5:0][TW-1:0] w;
    logic [7:0][DW-1:0] y;
  } vec_t;

  typedef struct packed {
    logic [8*DW-1:0] y;
    logic [31:0]     acc;
    logic            chk_lat;
  } sb_t;

  logic clk = 1'b0;
  logic rst_n, in_valid, in_ready, out_valid, out_ready, sat_sticky, sat_clr;
  logic signed [DW-1:0] ar, ai, br, bi, cr, ci, dr, di;
  logic signed [TW-1:0] w1r, w1i, w2r, w2i, w3r, w3i;
  logic signed [DW-1:0] y0r, y0i, y1r, y1i, y2r, y2i, y3r, y3i;
  logic [8*DW-1:0] ycat;

  int   checks = 0;
  int   errors = 0;
  int   cyc    = 0;
  sb_t  sbq[$];
  vec_t tab[8];

  assign ycat = {y0r, y0i, y1r, y1i, y2r, y2i, y3r, y3i};

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  ifft_r4_butterfly_pipe #(.DW(DW), .TW(TW), .TFRAC(14)) dut (
    .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .in_ready(in_ready),
    .ar(ar), .ai(ai), .br(br), .bi(bi), .cr(cr), .ci(ci), .dr(dr), .di(di),
    .w1r(w1r), .w1i(w1i), .w2r(w2r), .w2i(w2i), .w3r(w3r), .w3i(w3i),
    .out_valid(out_valid), .out_ready(out_ready),
    .y0r(y0r), .y0i(y0i), .y1r(y1r), .y1i(y1i),
    .y2r(y2r), .y2i(y2i), .y3r(y3r), .y3i(y3i),
    .sat_sticky(sat_sticky), .sat_clr(sat_clr)
  );

  function automatic logic [8*DW-1:0] p8(input int a, input int b, input int c, input int d,
                                         input int e, input int f, input int g, input int h);
    return {16'(a), 16'(b), 16'(c), 16'(d), 16'(e), 16'(f), 16'(g), 16'(h)};
  endfunction

  function automatic logic [6*TW-1:0] p6(input int a, input int b, input int c,
                                         input int d, input int e, input int f);
    return {16'(a), 16'(b), 16'(c), 16'(d), 16'(e), 16'(f)};
  endfunction

  function automatic longint clamp16(input longint v);
    if (v > 32767)  return 32767;
    if (v < -32768) return -32768;
    return v;
  endfunction

  // Reference: twiddle multiply (round half-up, clamp), inverse DFT, /4.
  function automatic logic [8*DW-1:0] model(input vec_t v);
    longint xr[3], xi[3], yr[4], yi[4];
    longint a_r, a_i, sr, si, wr, wi;
    logic [8*DW-1:0] res;
    a_r = longint'($signed(v.s[7]));
    a_i = longint'($signed(v.s[6]));
    for (int k = 0; k < 3; k++) begin
      sr = longint'($signed(v.s[5-2*k]));
      si = longint'($signed(v.s[4-2*k]));
      wr = longint'($signed(v.w[5-2*k]));
      wi = longint'($signed(v.w[4-2*k]));
      xr[k] = clamp16((sr*wr - si*wi + 8192) >>> 14);
      xi[k] = clamp16((sr*wi + si*wr + 8192) >>> 14);
    end
    yr[0] = a_r + xr[0] + xr[1] + xr[2];  yi[0] = a_i + xi[0] + xi[1] + xi[2];
    yr[1] = a_r - xi[0] - xr[1] + xi[2];  yi[1] = a_i + xr[0] - xi[1] - xr[2];
    yr[2] = a_r - xr[0] + xr[1] - xr[2];  yi[2] = a_i - xi[0] + xi[1] - xi[2];
    yr[3] = a_r + xi[0] - xr[1] - xi[2];  yi[3] = a_i - xr[0] - xi[1] + xr[2];
    res = '0;
    for (int j = 0; j < 4; j++) begin
      res[(7-2*j)*DW +: DW] = 16'((yr[j] + 2) >>> 2);
      res[(6-2*j)*DW +: DW] = 16'((yi[j] + 2) >>> 2);
    end
    return res;
  endfunction

  function automatic vec_t rnd_vec();
    vec_t v;
    for (int k = 0; k < 8; k++) v.s[k] = 16'($urandom_range(0, 65535));
    for (int k = 0; k < 6; k++) v.w[k] = 16'(int'($urandom_range(0, 32768)) - 16384);
    v.y = model(v);
    return v;
  endfunction

  task automatic check(input string name, input logic [8*DW-1:0] got, input logic [8*DW-1:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s got=%h exp=%h (t=%0t)", name, got, exp, $time);
    end
  endtask

  // Called at posedge+1; leaves in_valid high so calls can stream.
  task automatic send(input vec_t v, input bit lat, output int acc_cyc);
    bit done;
    done = 1'b0;
    acc_cyc = -1;
    {ar, ai, br, bi, cr, ci, dr, di} = v.s;
    {w1r, w1i, w2r, w2i, w3r, w3i}   = v.w;
    in_valid = 1'b1;
    for (int n = 0; n < 200 && !done; n++) begin
      @(negedge clk);
      if (in_ready) begin
        done = 1'b1;
        acc_cyc = cyc;
        sbq.push_back('{y: v.y, acc: 32'(cyc), chk_lat: lat});
      end
      @(posedge clk); #1;
    end
    if (!done) begin
      checks++; errors++;
      $display("FAIL send_timeout got=in_ready_low exp=accept");
    end
  endtask

  task automatic drain();
    for (int n = 0; n < 100 && sbq.size() != 0; n++) @(negedge clk);
    if (sbq.size() != 0) begin
      checks++; errors++;
      $display("FAIL drain_timeout got=%0d pending exp=0", sbq.size());
      sbq.delete();
    end
    @(posedge clk); #1;
  endtask

  // Output monitor: each handshake pops and compares one expected vector.
  initial begin : monitor
    sb_t e;
    forever begin
      @(negedge clk);
      if (out_valid && out_ready) begin
        if (sbq.size() == 0) begin
          checks++; errors++;
          $display("FAIL unexpected_output got=%h exp=none", ycat);
        end else begin
          e = sbq.pop_front();
          check("y_out", ycat, e.y);
          if (e.chk_lat) check("latency", 128'(cyc - int'(e.acc)), 128'(3));
        end
      end
    end
  end

  initial begin : watchdog
    #2000000;
    $display("FAIL watchdog got=timeout exp=finish");
    $display("CHECKS %0d ERRORS %0d", checks, errors + 1);
    $fatal(1);
  end

  initial begin : main
    logic [6*TW-1:0] uni;
    logic [8*DW-1:0] snap;
    int   c;
    bit   seen, stale;

    uni = p6(16384, 0, 16384, 0, 16384, 0);
    tab[0] = '{s: p8(400,0,0,0,0,0,0,0), w: uni,
               y: p8(100,0,100,0,100,0,100,0)};
    tab[1] = '{s: p8(0,0,400,0,0,0,0,0), w: uni,
               y: p8(100,0,0,100,-100,0,0,-100)};
    tab[2] = '{s: p8(0,0,1000,0,0,0,0,0), w: p6(0,16384,16384,0,16384,0),
               y: p8(0,250,-250,0,0,-250,250,0)};
    tab[3] = '{s: p8(0,0,32767,0,0,0,0,0), w: p6(32767,32767,16384,0,16384,0),
               y: p8(8192,8192,-8192,8192,-8192,-8192,8192,-8192)};
    tab[4] = '{s: p8(100,-200,40,8,-12,60,7,-5), w: uni,
               y: p8(34,-34,25,-57,10,-36,31,-73)};
    tab[5] = '{s: p8(0,0,0,0,0,0,3,0), w: p6(16384,0,16384,0,8192,0),
               y: p8(1,0,0,0,0,0,0,1)};
    tab[6] = '{s: p8(0,0,32767,0,0,0,0,0), w: p6(-32768,0,16384,0,16384,0),
               y: p8(-8192,0,0,-8192,8192,0,0,8192)};
    tab[7] = '{s: p8(32767,-32768,32767,-32768,32767,-32768,32767,-32768), w: uni,
               y: p8(32767,-32768,0,0,0,0,0,0)};

    rst_n = 1'b0; in_valid = 1'b0; out_ready = 1'b1; sat_clr = 1'b0;
    {ar, ai, br, bi, cr, ci, dr, di} = '0;
    {w1r, w1i, w2r, w2i, w3r, w3i}   = '0;

    // Reset state
    repeat (3) @(negedge clk);
    check("rst_out_valid", out_valid, 1'b0);
    check("rst_y", ycat, '0);
    check("rst_sticky", sat_sticky, 1'b0);
    check("rst_in_ready", in_ready, 1'b1);
    @(posedge clk); #1 rst_n = 1'b1;
    @(posedge clk); #1;

    // Directed table, one vector at a time with exact latency
    for (int i = 0; i < 8; i++) begin
      send(tab[i], 1'b1, c);
      in_valid = 1'b0;
      drain();
    end

    // Random back-to-back stream, full throughput
    for (int i = 0; i < 12; i++) send(rnd_vec(), 1'b1, c);
    in_valid = 1'b0;
    drain();

    // Sticky flag: clear, set by a saturating vector, survives clean vectors
    sat_clr = 1'b1; @(posedge clk); #1 sat_clr = 1'b0;
    @(negedge clk); check("sticky_cleared", sat_sticky, 1'b0);
    @(posedge clk); #1;
    send(tab[0], 1'b1, c); in_valid = 1'b0; drain();
    check("sticky_no_sat", sat_sticky, 1'b0);
    send(tab[3], 1'b1, c); in_valid = 1'b0; drain();
    check("sticky_set", sat_sticky, 1'b1);
    send(tab[4], 1'b1, c); in_valid = 1'b0; drain();
    check("sticky_holds", sat_sticky, 1'b1);
    sat_clr = 1'b1; @(posedge clk); #1 sat_clr = 1'b0;
    @(negedge clk); check("sticky_clr_pulse", sat_sticky, 1'b0);
    @(posedge clk); #1;

    // Set wins over a simultaneous clear; the held clear then takes effect
    sat_clr = 1'b1;
    send(tab[6], 1'b1, c); in_valid = 1'b0;
    @(negedge clk);
    @(negedge clk); check("sticky_set_wins", sat_sticky, 1'b1);
    @(negedge clk); check("sticky_then_clr", sat_sticky, 1'b0);
    @(posedge clk); #1 sat_clr = 1'b0;
    drain();

    // Backpressure: 8 streamed vectors, out_ready low 4 cycles after first output
    fork
      begin : bp_src
        int cc;
        for (int i = 0; i < 8; i++) send(rnd_vec(), 1'b0, cc);
        in_valid = 1'b0;
      end
      begin : bp_sink
        seen = 1'b0;
        for (int n = 0; n < 50 && !seen; n++) begin
          @(negedge clk);
          if (out_valid) seen = 1'b1;
        end
        check("bp_first_output", seen, 1'b1);
        @(posedge clk); #1;
        out_ready = 1'b0;
        snap = ycat;
        for (int i = 0; i < 4; i++) begin
          @(negedge clk);
          check("bp_in_ready_low", in_ready, 1'b0);
          check("bp_y_stable", ycat, snap);
          check("bp_out_valid_held", out_valid, 1'b1);
          @(posedge clk); #1;
        end
        out_ready = 1'b1;
      end
    join
    drain();

    // Reset with two vectors in flight; sticky is set by the first
    send(tab[3], 1'b0, c);
    send(tab[0], 1'b0, c);
    in_valid = 1'b0;
    check("pre_rst_sticky", sat_sticky, 1'b1);
    #2 rst_n = 1'b0;
    #1;
    check("mid_rst_out_valid", out_valid, 1'b0);
    check("mid_rst_y", ycat, '0);
    check("mid_rst_sticky", sat_sticky, 1'b0);
    check("mid_rst_in_ready", in_ready, 1'b1);
    sbq.delete();
    @(posedge clk); @(posedge clk); #1 rst_n = 1'b1;
    stale = 1'b0;
    repeat (6) begin
      @(negedge clk);
      if (out_valid) stale = 1'b1;
    end
    check("no_stale_output", stale, 1'b0);
    @(posedge clk); #1;
    send(tab[1], 1'b1, c); in_valid = 1'b0;
    drain();

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
